// File: rtl/billiard_pkg.sv
// Shared types and helpers for the billiard collision pipeline.
package billiard_pkg;

  localparam int unsigned BALL_DIAMETER = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESOLVE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  function automatic int unsigned pair_count(input int unsigned n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/pair_index_counter.sv
// Walks unordered ball pairs (i<j) in scan order, with a linear pair index k.
module pair_index_counter
  import billiard_pkg::*;
#(
  parameter int unsigned NUM_BALLS = 16,
  localparam int unsigned IW = $clog2(NUM_BALLS),
  localparam int unsigned P  = pair_count(NUM_BALLS),
  localparam int unsigned KW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [IW-1:0] idxA_o,
  output logic [IW-1:0] idxB_o,
  output logic [KW-1:0] k_o,
  output logic          last_o
);

  logic [IW-1:0] i_q;
  logic [IW-1:0] j_q;
  logic [KW-1:0] k_q;

  assign idxA_o = i_q;
  assign idxB_o = j_q;
  assign k_o    = k_q;
  assign last_o = (i_q == IW'(NUM_BALLS - 2)) && (j_q == IW'(NUM_BALLS - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (clear_i) begin
      i_q <= '0;
      j_q <= IW'(1);
      k_q <= '0;
    end else if (step_i && !last_o) begin
      // Row wrap: next pair starts right above the new lower index.
      if (j_q == IW'(NUM_BALLS - 1)) begin
        i_q <= i_q + IW'(1);
        j_q <= i_q + IW'(2);
      end else begin
        j_q <= j_q + IW'(1);
      end
      k_q <= k_q + KW'(1);
    end
  end

endmodule

// File: rtl/ball_pair_scheduler.sv
// Per-frame pair scheduler sharing one collision resolver among all balls;
// a per-pair armed bit stops the same contact being resolved twice.
module ball_pair_scheduler
  import billiard_pkg::*;
#(
  parameter int unsigned NUM_BALLS       = 16,
  parameter int unsigned CHECK_LATENCY   = 1,
  parameter int unsigned RESOLVE_TIMEOUT = 64,
  localparam int unsigned IW = $clog2(NUM_BALLS)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          startOfFrame,
  output logic [IW-1:0] pairIdxA,
  output logic [IW-1:0] pairIdxB,
  output logic          pairValid,
  input  logic          overlap,
  input  logic          separated,
  output logic          resolveReq,
  input  logic          resolveDone,
  output logic [7:0]    collisionCount,
  output logic          frameDone,
  output logic          overrun,
  output logic          timeoutErr
);

  localparam int unsigned P  = pair_count(NUM_BALLS);
  localparam int unsigned KW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned CW = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;
  localparam int unsigned TW = (RESOLVE_TIMEOUT > 1) ? $clog2(RESOLVE_TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ISSUE   = ISSUE;
  localparam logic [2:0] S_WAIT    = WAIT;
  localparam logic [2:0] S_RESOLVE = RESOLVE;
  localparam logic [2:0] S_DONE    = DONE;

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] wait_q,   wait_d;
  logic [TW-1:0] tmo_q,    tmo_d;
  logic [P-1:0]  armed_q,  armed_d;
  logic [7:0]    count_q,  count_d;
  logic          tmoerr_q, tmoerr_d;

  logic          ctr_clear;
  logic          ctr_step;
  logic          advance;
  logic [KW-1:0] pair_k;
  logic          pair_last;

  pair_index_counter #(
    .NUM_BALLS(NUM_BALLS)
  ) u_pair_ctr (
    .clk    (clk),
    .resetN (resetN),
    .clear_i(ctr_clear),
    .step_i (ctr_step),
    .idxA_o (pairIdxA),
    .idxB_o (pairIdxB),
    .k_o    (pair_k),
    .last_o (pair_last)
  );

  assign pairValid      = (state_q == S_ISSUE);
  assign resolveReq     = (state_q == S_RESOLVE);
  assign frameDone      = (state_q == S_DONE);
  assign overrun        = startOfFrame && (state_q != S_IDLE);
  assign timeoutErr     = tmoerr_q;
  assign collisionCount = count_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    armed_d   = armed_q;
    count_d   = count_q;
    tmoerr_d  = 1'b0;
    ctr_clear = 1'b0;
    ctr_step  = 1'b0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (startOfFrame) begin
          state_d   = S_ISSUE;
          ctr_clear = 1'b1;
          count_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = CW'(CHECK_LATENCY - 1);
      end
      S_WAIT: begin
        // separated wins over overlap so a confused checker never fires a resolve.
        if (wait_q != '0) begin
          wait_d = wait_q - CW'(1);
        end else if (separated) begin
          armed_d[pair_k] = 1'b1;
          advance         = 1'b1;
        end else if (overlap && armed_q[pair_k]) begin
          armed_d[pair_k] = 1'b0;
          state_d         = S_RESOLVE;
          tmo_d           = TW'(RESOLVE_TIMEOUT - 1);
        end else begin
          advance = 1'b1;
        end
      end
      S_RESOLVE: begin
        if (resolveDone) begin
          if (count_q != '1) count_d = count_q + 8'd1;
          advance = 1'b1;
        end else if (tmo_q == '0) begin
          tmoerr_d = 1'b1;
          advance  = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (pair_last) begin
        state_d = S_DONE;
      end else begin
        state_d  = S_ISSUE;
        ctr_step = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      tmo_q    <= '0;
      armed_q  <= '1;
      count_q  <= '0;
      tmoerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      armed_q  <= armed_d;
      count_q  <= count_d;
      tmoerr_q <= tmoerr_d;
    end
  end

endmodule

// File: tb/tb_ball_pair_scheduler.sv
// Directed frame-by-frame bench for ball_pair_scheduler with four balls.
module tb_ball_pair_scheduler;

  localparam int NB = 4;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [1:0] pairIdxA;
  logic [1:0] pairIdxB;
  logic       pairValid;
  logic       overlap;
  logic       separated;
  logic       resolveReq;
  logic       resolveDone;
  logic [7:0] collisionCount;
  logic       frameDone;
  logic       overrun;
  logic       timeoutErr;

  ball_pair_scheduler #(
    .NUM_BALLS(NB),
    .CHECK_LATENCY(1),
    .RESOLVE_TIMEOUT(64)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .pairIdxA      (pairIdxA),
    .pairIdxB      (pairIdxB),
    .pairValid     (pairValid),
    .overlap       (overlap),
    .separated     (separated),
    .resolveReq    (resolveReq),
    .resolveDone   (resolveDone),
    .collisionCount(collisionCount),
    .frameDone     (frameDone),
    .overrun       (overrun),
    .timeoutErr    (timeoutErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overlap checker model: per-pair masks looked up by the presented pair.
  logic [5:0] cur_ov;
  logic [5:0] cur_sep;
  int         pk;
  assign pk = int'(pairIdxA) * (2 * NB - 1 - int'(pairIdxA)) / 2
            + int'(pairIdxB) - int'(pairIdxA) - 1;
  assign overlap   = (pk >= 0 && pk < 6) ? cur_ov[pk[2:0]]  : 1'b0;
  assign separated = (pk >= 0 && pk < 6) ? cur_sep[pk[2:0]] : 1'b0;

  typedef struct {
    logic [5:0] ov;
    logic [5:0] sep;
    int         done_dly;   // resolveDone age after resolveReq rise; -1 never
    int         ovr_at;     // cycle after start to pulse startOfFrame again; -1 none
    int         res_k;      // pair expected to be resolved; -1 none
    int         stall;      // cycles resolveReq is expected high
    int         exp_tmo;
    int         exp_count;
  } vec_t;

  vec_t vecs[14];
  int   expA[6] = '{0, 0, 0, 1, 1, 2};
  int   expB[6] = '{1, 2, 3, 2, 3, 3};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pairValid"},  int'(pairValid),      0);
    check({tag, "_resolveReq"}, int'(resolveReq),     0);
    check({tag, "_frameDone"},  int'(frameDone),      0);
    check({tag, "_overrun"},    int'(overrun),        0);
    check({tag, "_timeoutErr"}, int'(timeoutErr),     0);
    check({tag, "_count"},      int'(collisionCount), 0);
    check({tag, "_idxA"},       int'(pairIdxA),       0);
    check({tag, "_idxB"},       int'(pairIdxB),       0);
  endtask

  // Runs one frame from a negedge; ends on a negedge.
  task automatic run_frame(input int f);
    vec_t  v;
    int    rel, e, exp_rel, req_n, req_rise, req_hi, idx_err, seq_err;
    int    tmo_n, tmo_rel, ovr_n, ovr_rel, fd_rel;
    logic  prev_req;
    string t;
    v = vecs[f];
    t = $sformatf("f%0d", f);
    cur_ov = v.ov;
    cur_sep = v.sep;
    e = 0; req_n = 0; req_rise = -1; req_hi = 0; idx_err = 0; seq_err = 0;
    tmo_n = 0; tmo_rel = -1; ovr_n = 0; ovr_rel = -1; fd_rel = -1;
    prev_req = 1'b0;
    startOfFrame = 1'b1;
    rel = 0;
    while (fd_rel < 0 && rel < 13 + v.stall + 20) begin
      @(negedge clk);
      rel++;
      startOfFrame = 1'b0;
      resolveDone = 1'b0;
      if (pairValid) begin
        if (e < 6) begin
          exp_rel = 1 + 2 * e + ((v.res_k >= 0 && e > v.res_k) ? v.stall : 0);
          if (int'(pairIdxA) != expA[e] || int'(pairIdxB) != expB[e] || rel != exp_rel)
            seq_err++;
        end else begin
          seq_err++;
        end
        e++;
      end
      if (resolveReq) begin
        if (!prev_req) begin
          req_n++;
          req_rise = rel;
        end
        req_hi++;
        if (v.res_k >= 0 &&
            (int'(pairIdxA) != expA[v.res_k] || int'(pairIdxB) != expB[v.res_k]))
          idx_err++;
        if (rel - req_rise == v.done_dly) resolveDone = 1'b1;
      end
      prev_req = resolveReq;
      if (timeoutErr) begin
        tmo_n++;
        tmo_rel = rel;
      end
      if (frameDone) fd_rel = rel;
      if (rel == v.ovr_at) startOfFrame = 1'b1;
      #1;
      if (overrun) begin
        ovr_n++;
        ovr_rel = rel;
      end
    end
    @(negedge clk);
    startOfFrame = 1'b0;
    resolveDone = 1'b0;
    @(negedge clk);

    check({t, "_frameDone_at"}, fd_rel,  13 + v.stall);
    check({t, "_pair_pulses"},  e,       6);
    check({t, "_pair_seq_err"}, seq_err, 0);
    check({t, "_req_count"},    req_n,   (v.res_k >= 0) ? 1 : 0);
    if (v.res_k >= 0) begin
      check({t, "_req_rise"},    req_rise, 1 + 2 * v.res_k + 2);
      check({t, "_req_cycles"},  req_hi,   v.stall);
      check({t, "_req_idx_err"}, idx_err,  0);
    end
    check({t, "_timeouts"}, tmo_n, v.exp_tmo);
    if (v.exp_tmo != 0) check({t, "_timeout_at"}, tmo_rel, req_rise + 64);
    check({t, "_overruns"}, ovr_n, (v.ovr_at >= 0) ? 1 : 0);
    if (v.ovr_at >= 0) check({t, "_overrun_at"}, ovr_rel, v.ovr_at);
    check({t, "_collisionCount"}, int'(collisionCount), v.exp_count);
  endtask

  logic seen;

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    resolveDone = 1'b0;
    cur_ov = '0;
    cur_sep = '1;

    //          ov     sep    dly ovr  res stall tmo cnt
    vecs[0]  = '{6'h00, 6'h3F, 0, -1, -1, 0,  0, 0};  // clean scan
    vecs[1]  = '{6'h08, 6'h37, 5, -1,  3, 6,  0, 1};  // (1,2) collides
    vecs[2]  = '{6'h08, 6'h37, 5, -1, -1, 0,  0, 0};  // still touching: no re-resolve
    vecs[3]  = '{6'h00, 6'h3F, 0, -1, -1, 0,  0, 0};  // separated: re-arm
    vecs[4]  = '{6'h08, 6'h37, 5, -1,  3, 6,  0, 1};  // collides again
    vecs[5]  = '{6'h00, 6'h3F, 0, -1, -1, 0,  0, 0};
    vecs[6]  = '{6'h08, 6'h37, -1, -1, 3, 64, 1, 0};  // resolver never answers
    vecs[7]  = '{6'h08, 6'h37, 5, -1, -1, 0,  0, 0};  // abandoned pair stays disarmed
    vecs[8]  = '{6'h00, 6'h3F, 0,  6, -1, 0,  0, 0};  // overrun mid-scan
    vecs[9]  = '{6'h00, 6'h3F, 0, 13, -1, 0,  0, 0};  // overrun in DONE cycle
    vecs[10] = '{6'h08, 6'h3F, 0, -1, -1, 0,  0, 0};  // overlap+separated -> separated
    vecs[11] = '{6'h08, 6'h37, 0, -1,  3, 1,  0, 1};  // done in first RESOLVE cycle
    vecs[12] = '{6'h00, 6'h3F, 0, -1, -1, 0,  0, 0};  // re-arm before reset test
    vecs[13] = '{6'h08, 6'h37, 5, -1,  3, 6,  0, 1};  // after reset: armed again

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    for (int f = 0; f < 13; f++) run_frame(f);

    // Reset while a resolve is outstanding
    cur_ov = 6'h08;
    cur_sep = 6'h37;
    startOfFrame = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      startOfFrame = 1'b0;
      if (resolveReq) seen = 1'b1;
    end
    check("rst_pre_req_seen", int'(seen), 1);
    resetN = 1'b0;
    #1;
    check_outputs_zero("rst_mid_resolve");
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    run_frame(13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ball_pair_scheduler.md
Name: ball_pair_scheduler

Overview:
- Per-frame scheduler that shares one ball_collision resolver among NUM_BALLS balls.
- On each start-of-frame it walks every unordered ball pair (i<j) and presents the pair indices to an external position mux and overlap checker.
- It fires one resolve handshake per newly-overlapping pair.
- It keeps a per-pair "armed" bit: a pair cannot re-collide until it has separated, so the same contact is never resolved twice across frames.

Parameters:
- NUM_BALLS, 16, number of balls; pair count P = NUM_BALLS*(NUM_BALLS-1)/2.
- CHECK_LATENCY, 1, cycles from pairValid to valid overlap/separated inputs (>=1).
- RESOLVE_TIMEOUT, 64, max cycles to wait for resolveDone before abandoning the pair.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse; begins a scan.
- pairIdxA  out  IW=$clog2(NUM_BALLS)  lower ball index of current pair.
- pairIdxB  out  IW  upper ball index (always > pairIdxA).
- pairValid  out  1  one-cycle pulse; a new pair is on pairIdxA/B.
- overlap  in  1  centre distance <= BALL_DIAMETER; sampled CHECK_LATENCY cycles after pairValid.
- separated  in  1  |dx|>BALL_DIAMETER or |dy|>BALL_DIAMETER; sampled with overlap.
- resolveReq  out  1  level; asks the resolver to process pairIdxA/B.
- resolveDone  in  1  one-cycle pulse; resolver has written back velocities.
- collisionCount  out  8  resolves completed this frame, saturating at 255.
- frameDone  out  1  one-cycle pulse; scan finished.
- overrun  out  1  one-cycle pulse; startOfFrame arrived while not IDLE.
- timeoutErr  out  1  one-cycle pulse; a resolve was abandoned.

Behaviour:
- Reset (async): state IDLE; all outputs 0; pairIdxA/B=0; armed bitmap all 1; collisionCount=0.
- States: IDLE, ISSUE, WAIT, RESOLVE, DONE.
- IDLE: on startOfFrame -> ISSUE with pair (0,1); collisionCount cleared the same edge.
- ISSUE: pairValid=1 for exactly one cycle -> WAIT; wait counter loaded with CHECK_LATENCY-1.
- WAIT: counts down; at 0, sample overlap and separated:
  - separated=1: set armed[k], advance.
  - overlap=1 and armed[k]=1: clear armed[k] -> RESOLVE.
  - overlap=1 and armed[k]=0: advance (contact already handled).
  - both 0: advance, armed unchanged.
  - overlap and separated both 1: treat as separated (checker error).
- Advance: next pair in order (0,1),(0,2)...(0,N-1),(1,2)...(N-2,N-1) -> ISSUE. After the last pair -> DONE.
- Timing without collisions: each pair costs CHECK_LATENCY+1 cycles. frameDone is asserted P*(CHECK_LATENCY+1)+1 cycles after startOfFrame.
- RESOLVE:
  - resolveReq held at 1; pairIdxA/B held stable.
  - resolveDone -> resolveReq=0 the next cycle, collisionCount+1 (saturating), advance.
  - Timeout counter expiring (RESOLVE_TIMEOUT cycles without resolveDone) -> timeoutErr pulse, resolveReq=0, armed[k] remains 0, advance.
- DONE: frameDone=1 for one cycle -> IDLE. collisionCount holds until the next startOfFrame.
- Linear pair index k = position in the scan order; the armed bitmap is P bits.
- startOfFrame while not IDLE: ignored (scan continues), overrun pulses that cycle. startOfFrame in the DONE cycle also counts as overrun.
- resolveDone outside RESOLVE: ignored.
- Only one resolveReq outstanding at any time.
- Reset asserted mid-scan or mid-resolve: immediate return to the reset state, armed bits re-armed.

Decomposition:
- billiard_pkg holds:
  - BALL_DIAMETER = 32.
  - sched_state_t enum {IDLE, ISSUE, WAIT, RESOLVE, DONE}.
  - function pair_count(n).
- Sub-module pair_index_counter: generates (i,j,k).
  - Inputs: clear, step.
  - Outputs: idxA, idxB, linear index k, last.
  - Step rule: j++; when j wraps, i++ and j=i+1.

Test Plan:
- NUM_BALLS=4, CHECK_LATENCY=1, overlap=0, separated=1, startOfFrame at t0 -> pairValid pulses for (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) every 2 cycles; frameDone at t0+13; collisionCount=0.
- Overlap=1 only for pair (1,2); resolveDone 5 cycles after resolveReq rises -> exactly one resolveReq with pairIdxA=1/B=2 stable throughout; collisionCount=1; frameDone delayed by 6 cycles versus the previous case.
- Same pair still overlapping next frame (separated=0) -> no resolveReq. Third frame with separated=1 for (1,2), fourth frame overlap again -> resolveReq fires in frame four.
- resolveDone never asserted, RESOLVE_TIMEOUT=64 -> timeoutErr pulse 64 cycles after resolveReq rises; scan continues to (1,3); frame completes.
- startOfFrame pulsed mid-scan -> overrun=1 for one cycle; pair sequence and frameDone timing unchanged.
- resetN low while in RESOLVE -> resolveReq=0 and all outputs 0 immediately; after release, a new frame resolves a previously disarmed pair again (armed restored).
